micro_result_checker: RTL and testbench
=======================================

MICRO_RESULT_CHECKER -- requirements
Module: micro_result_checker

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the operand width; the sweep covers 0..2^DATA_W-1 per operand.
REQ-002 Parameter ADDR_W, default 8, SHALL set the program-counter width.
REQ-003 Parameter CHECK_PC, default 8'd8, SHALL set the instruction address at which a result is valid.
REQ-004 Parameter TIMEOUT_CYCLES, default 4096, SHALL set the maximum number of cycles allowed between check points.
REQ-005 _iClk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-006 _iReset  in  1  SHALL be an asynchronous, active-low reset.
REQ-007 _iStart  in  1  SHALL be a one-cycle start pulse.
REQ-008 _iOpSel  in  3  SHALL select the operation: ADD, SUB, NAND, NOR, XOR, XNOR, MULT.
REQ-009 _iPc  in  ADDR_W  SHALL carry the DUV instruction address.
REQ-010 _iResLo / _iResHi  in  DATA_W each  SHALL carry the DUV result words; _iResHi is used only for MULT.
REQ-011 _oOpA / _oOpB  out  DATA_W  SHALL present the expected current operands: A is the inner loop, B is the outer loop.
REQ-012 _oBusy, _oDone, _oTimeout, _oMismatch  out  1  SHALL be the status flags; _oMismatch is a one-cycle pulse.
REQ-013 _oErrCnt / _oOkCnt  out  2*DATA_W+1  SHALL be the saturating-free error and pass counters.

Function
REQ-014 The FSM SHALL have the states IDLE, ARM, CHECK, LEAVE and DONE.
REQ-015 IDLE->ARM SHALL occur on _iStart; this transition clears the counters, operands, _oDone and _oTimeout, and latches _iOpSel.
REQ-016 ARM->CHECK SHALL occur on the first cycle in which _iPc==CHECK_PC.
REQ-017 CHECK SHALL last exactly one cycle and compare the DUV result against the golden result of the registered operands.
REQ-018 The golden result SHALL be as follows: ADD and SUB are A+B and A-B mod 2^DATA_W; NAND, NOR, XOR and XNOR are bitwise; MULT is the full 2*DATA_W-bit product {ResHi,ResLo}.
REQ-019 On a match, CHECK SHALL increment _oOkCnt.
REQ-020 On a mismatch, CHECK SHALL increment _oErrCnt and pulse _oMismatch in the same cycle.
REQ-021 CHECK->LEAVE SHALL be unconditional.
REQ-022 In LEAVE, the FSM SHALL wait until _iPc!=CHECK_PC, then advance the operands and return to ARM.
REQ-023 If A and B are both at their maximum when the FSM leaves LEAVE, it SHALL instead go to DONE and assert _oDone.
REQ-024 Operand advance SHALL increment A; when A wraps from 2^DATA_W-1 to 0, B SHALL increment.
REQ-025 A timeout counter SHALL restart on every entry to ARM.
REQ-026 If TIMEOUT_CYCLES elapses in ARM or LEAVE without the awaited PC condition, the FSM SHALL go to DONE with _oTimeout=1 and _oDone=1.
REQ-027 _oBusy SHALL be 1 in ARM, CHECK and LEAVE, and 0 in IDLE and DONE.
REQ-028 _iStart SHALL be ignored while busy; from DONE, _iStart SHALL restart the sweep as from IDLE.
REQ-029 _iPc equal to CHECK_PC on the same cycle as _iStart SHALL NOT count as a hit; ARM samples from the next cycle.
REQ-030 A full sweep SHALL yield _oOkCnt+_oErrCnt = 2^(2*DATA_W) exactly, with no counter overflow.

Reset
REQ-031 Asserting _iReset low SHALL immediately force IDLE, zero the counters and operands, and deassert all flags, including mid-sweep.
REQ-032 After _iReset deasserts, the block SHALL remain in IDLE until _iStart.

Configuration
REQ-033 With CHECKER_FIRST_ERR_CAPTURE_EN defined, the block SHALL add outputs _oFirstErrA, _oFirstErrB and _oFirstErrVal (2*DATA_W).
REQ-034 Those outputs SHALL latch the first mismatch after _iStart and hold until the next _iStart or reset.
REQ-035 Without CHECKER_FIRST_ERR_CAPTURE_EN, those ports and registers SHALL be absent.

Structure
REQ-036 Package micro_checker_pkg SHALL hold the op_sel_t enum, the state_t enum and the op-code constants.
REQ-037 Golden-result computation SHALL be a combinational sub-module, micro_golden_alu, parametrised by DATA_W.

Verification
REQ-038 DATA_W=2, ADD, correct model returning A+B at PC=8 -> _oDone, _oOkCnt=16, _oErrCnt=0.
REQ-039 DATA_W=2, MULT, model corrupting result bit0 when A=3,B=3 -> one _oMismatch pulse, _oErrCnt=1; with macro, FirstErrA=3, FirstErrB=3, FirstErrVal=8.
REQ-040 PC held at 8 for 5 cycles -> exactly one CHECK; operands advance only after PC leaves 8.
REQ-041 TIMEOUT_CYCLES=16, PC never reaches CHECK_PC -> _oTimeout=1 and _oDone=1 at cycle 17 after ARM entry.
REQ-042 _iReset low mid-sweep with A=2,B=1 -> IDLE with counters=0; new _iStart -> sweep restarts at A=0,B=0.
REQ-043 _iStart pulsed while busy, and _iPc=CHECK_PC on the _iStart cycle -> both ignored; counts unaffected.

Source files
------------

// File: rtl/micro_checker_pkg.sv
// Shared types and op-code constants for the micro result checker.
// Optional feature macro used by the top: CHECKER_FIRST_ERR_CAPTURE_EN.
package micro_checker_pkg;

    localparam logic [2:0] OPC_ADD  = 3'd0;
    localparam logic [2:0] OPC_SUB  = 3'd1;
    localparam logic [2:0] OPC_NAND = 3'd2;
    localparam logic [2:0] OPC_NOR  = 3'd3;
    localparam logic [2:0] OPC_XOR  = 3'd4;
    localparam logic [2:0] OPC_XNOR = 3'd5;
    localparam logic [2:0] OPC_MULT = 3'd6;

    typedef enum logic [2:0] {
        OP_ADD  = OPC_ADD,
        OP_SUB  = OPC_SUB,
        OP_NAND = OPC_NAND,
        OP_NOR  = OPC_NOR,
        OP_XOR  = OPC_XOR,
        OP_XNOR = OPC_XNOR,
        OP_MULT = OPC_MULT
    } op_sel_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARM   = 3'd1,
        S_CHECK = 3'd2,
        S_LEAVE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/micro_golden_alu.sv
// Combinational golden model: expected DUV result for the current operands.
// Non-MULT results occupy the low DATA_W bits; the upper half is zero.
module micro_golden_alu
    import micro_checker_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0]   i_a,
    input  logic [DATA_W-1:0]   i_b,
    input  op_sel_t             i_op,
    output logic [2*DATA_W-1:0] o_y
);

    // Select the reference operation; arithmetic wraps modulo 2^DATA_W except MULT
    always_comb begin
        o_y = '0;
        case (i_op)
            OP_ADD:  o_y[DATA_W-1:0] = i_a + i_b;
            OP_SUB:  o_y[DATA_W-1:0] = i_a - i_b;
            OP_NAND: o_y[DATA_W-1:0] = ~(i_a & i_b);
            OP_NOR:  o_y[DATA_W-1:0] = ~(i_a | i_b);
            OP_XOR:  o_y[DATA_W-1:0] = i_a ^ i_b;
            OP_XNOR: o_y[DATA_W-1:0] = ~(i_a ^ i_b);
            OP_MULT: o_y = {{DATA_W{1'b0}}, i_a} * {{DATA_W{1'b0}}, i_b};
            default: o_y = '0;
        endcase
    end

endmodule

// File: rtl/micro_result_checker.sv
// Exhaustive operand sweeper / result checker for a small DUV.
// Presents operands A (inner) and B (outer), waits for the DUV to reach
// CHECK_PC, compares its result against the golden ALU, and counts pass/fail.
// Optional first-mismatch capture: define CHECKER_FIRST_ERR_CAPTURE_EN.
module micro_result_checker
    import micro_checker_pkg::*;
#(
    parameter int                DATA_W         = 8,
    parameter int                ADDR_W         = 8,
    parameter logic [ADDR_W-1:0] CHECK_PC       = ADDR_W'(8),
    parameter int                TIMEOUT_CYCLES = 4096
) (
    input  logic                  _iClk,
    input  logic                  _iReset,
    input  logic                  _iStart,
    input  logic [2:0]            _iOpSel,
    input  logic [ADDR_W-1:0]     _iPc,
    input  logic [DATA_W-1:0]     _iResLo,
    input  logic [DATA_W-1:0]     _iResHi,
    output logic [DATA_W-1:0]     _oOpA,
    output logic [DATA_W-1:0]     _oOpB,
    output logic                  _oBusy,
    output logic                  _oDone,
    output logic                  _oTimeout,
    output logic                  _oMismatch,
    output logic [2*DATA_W:0]     _oErrCnt,
    output logic [2*DATA_W:0]     _oOkCnt
`ifdef CHECKER_FIRST_ERR_CAPTURE_EN
    ,
    output logic [DATA_W-1:0]     _oFirstErrA,
    output logic [DATA_W-1:0]     _oFirstErrB,
    output logic [2*DATA_W-1:0]   _oFirstErrVal
`endif
);

    localparam int CNT_W = 2*DATA_W + 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;

    state_t              r_state;
    state_t              w_state_nxt;
    op_sel_t             r_op;
    logic [DATA_W-1:0]   r_op_a;
    logic [DATA_W-1:0]   r_op_b;
    logic [CNT_W-1:0]    r_err_cnt;
    logic [CNT_W-1:0]    r_ok_cnt;
    logic                r_done;
    logic                r_timeout;
    logic                r_mismatch;
    logic [TMO_W-1:0]    r_tmo;

    logic                w_start;
    logic                w_do_check;
    logic                w_advance;
    logic                w_finish;
    logic                w_tmo_hit;
    logic                w_pc_hit;
    logic                w_last;
    logic                w_tmo_exp;
    logic                w_match;
    logic [2*DATA_W-1:0] w_gold;
    logic [2*DATA_W-1:0] w_obs;

    assign w_pc_hit  = (_iPc == CHECK_PC);
    assign w_last    = (&r_op_a) & (&r_op_b);
    assign w_tmo_exp = (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1));

    micro_golden_alu #(.DATA_W(DATA_W)) u_gold (
        .i_a  (r_op_a),
        .i_b  (r_op_b),
        .i_op (r_op),
        .o_y  (w_gold)
    );

    // Only MULT produces a high word; other ops ignore _iResHi
    assign w_obs   = (r_op == OP_MULT) ? {_iResHi, _iResLo} : {{DATA_W{1'b0}}, _iResLo};
    assign w_match = (w_obs == w_gold);

    // State register
    always_ff @(posedge _iClk or negedge _iReset) begin
        if (!_iReset) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next-state and datapath strobes
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_do_check  = 1'b0;
        w_advance   = 1'b0;
        w_finish    = 1'b0;
        w_tmo_hit   = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (_iStart) begin
                    w_state_nxt = S_ARM;
                    w_start     = 1'b1;
                end
            end
            S_ARM: begin
                // A hit on the final timer cycle still wins over the timeout
                if (w_pc_hit) begin
                    w_state_nxt = S_CHECK;
                end else if (w_tmo_exp) begin
                    w_state_nxt = S_DONE;
                    w_tmo_hit   = 1'b1;
                end
            end
            S_CHECK: begin
                w_do_check  = 1'b1;
                w_state_nxt = S_LEAVE;
            end
            S_LEAVE: begin
                if (!w_pc_hit) begin
                    if (w_last) begin
                        w_state_nxt = S_DONE;
                        w_finish    = 1'b1;
                    end else begin
                        w_state_nxt = S_ARM;
                        w_advance   = 1'b1;
                    end
                end else if (w_tmo_exp) begin
                    w_state_nxt = S_DONE;
                    w_tmo_hit   = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Wait timer: restarts on every state change, so ARM and LEAVE each get a full budget
    always_ff @(posedge _iClk or negedge _iReset) begin
        if (!_iReset)                    r_tmo <= '0;
        else if (w_state_nxt != r_state) r_tmo <= '0;
        else if (r_state == S_ARM || r_state == S_LEAVE) r_tmo <= r_tmo + 1'b1;
    end

    // Operands, counters and status flags
    always_ff @(posedge _iClk or negedge _iReset) begin
        if (!_iReset) begin
            r_op       <= OP_ADD;
            r_op_a     <= '0;
            r_op_b     <= '0;
            r_err_cnt  <= '0;
            r_ok_cnt   <= '0;
            r_done     <= 1'b0;
            r_timeout  <= 1'b0;
            r_mismatch <= 1'b0;
        end else begin
            r_mismatch <= w_do_check && !w_match;
            if (w_start) begin
                r_op      <= op_sel_t'(_iOpSel);
                r_op_a    <= '0;
                r_op_b    <= '0;
                r_err_cnt <= '0;
                r_ok_cnt  <= '0;
                r_done    <= 1'b0;
                r_timeout <= 1'b0;
            end
            if (w_do_check) begin
                if (w_match) r_ok_cnt  <= r_ok_cnt + 1'b1;
                else         r_err_cnt <= r_err_cnt + 1'b1;
            end
            if (w_advance) begin
                r_op_a <= r_op_a + 1'b1;
                if (&r_op_a) r_op_b <= r_op_b + 1'b1;
            end
            if (w_finish) r_done <= 1'b1;
            if (w_tmo_hit) begin
                r_done    <= 1'b1;
                r_timeout <= 1'b1;
            end
        end
    end

`ifdef CHECKER_FIRST_ERR_CAPTURE_EN
    logic                r_first_vld;
    logic [DATA_W-1:0]   r_first_a;
    logic [DATA_W-1:0]   r_first_b;
    logic [2*DATA_W-1:0] r_first_val;

    // Capture operands and observed DUV value of the first mismatch of a sweep
    always_ff @(posedge _iClk or negedge _iReset) begin
        if (!_iReset) begin
            r_first_vld <= 1'b0;
            r_first_a   <= '0;
            r_first_b   <= '0;
            r_first_val <= '0;
        end else if (w_start) begin
            r_first_vld <= 1'b0;
            r_first_a   <= '0;
            r_first_b   <= '0;
            r_first_val <= '0;
        end else if (w_do_check && !w_match && !r_first_vld) begin
            r_first_vld <= 1'b1;
            r_first_a   <= r_op_a;
            r_first_b   <= r_op_b;
            r_first_val <= w_obs;
        end
    end

    assign _oFirstErrA   = r_first_a;
    assign _oFirstErrB   = r_first_b;
    assign _oFirstErrVal = r_first_val;
`endif

    assign _oOpA      = r_op_a;
    assign _oOpB      = r_op_b;
    assign _oBusy     = (r_state == S_ARM) || (r_state == S_CHECK) || (r_state == S_LEAVE);
    assign _oDone     = r_done;
    assign _oTimeout  = r_timeout;
    assign _oMismatch = r_mismatch;
    assign _oErrCnt   = r_err_cnt;
    assign _oOkCnt    = r_ok_cnt;

endmodule

// File: tb/tb_micro_result_checker.sv
// Directed/randomized bench for micro_result_checker (DATA_W=2, TIMEOUT_CYCLES=16).
// A behavioural DUV model walks the PC, dwelling at 8 for random lengths, and
// returns results computed from plain arithmetic on the bench's own operand count.
module tb_micro_result_checker;

    localparam int DW  = 2;
    localparam int M   = 1 << DW;
    localparam int NV  = M * M;
    localparam int TMO = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [2:0]      opsel = 3'd0;
    logic [7:0]      pc = 8'd0;
    logic [DW-1:0]   res_lo = '0;
    logic [DW-1:0]   res_hi = '0;
    logic [DW-1:0]   op_a, op_b;
    logic            busy, done, tmo, mis;
    logic [2*DW:0]   err_cnt, ok_cnt;
`ifdef CHECKER_FIRST_ERR_CAPTURE_EN
    logic [DW-1:0]   fe_a, fe_b;
    logic [2*DW-1:0] fe_val;
`endif

    int n_vec = 0;
    int n_bad = 0;
    int mis_pulses = 0;

    micro_result_checker #(
        .DATA_W(DW), .ADDR_W(8), .CHECK_PC(8'd8), .TIMEOUT_CYCLES(TMO)
    ) dut (
        ._iClk(clk), ._iReset(rst_n), ._iStart(start), ._iOpSel(opsel),
        ._iPc(pc), ._iResLo(res_lo), ._iResHi(res_hi),
        ._oOpA(op_a), ._oOpB(op_b), ._oBusy(busy), ._oDone(done),
        ._oTimeout(tmo), ._oMismatch(mis), ._oErrCnt(err_cnt), ._oOkCnt(ok_cnt)
`ifdef CHECKER_FIRST_ERR_CAPTURE_EN
        , ._oFirstErrA(fe_a), ._oFirstErrB(fe_b), ._oFirstErrVal(fe_val)
`endif
    );

    always #5 clk = ~clk;

    // Count every cycle the mismatch flag is high, sampled away from the active edge
    always @(negedge clk) if (mis === 1'b1) mis_pulses <= mis_pulses + 1;

    function automatic int gold(input int op, input int a, input int b);
        case (op)
            0: return (a + b) % M;
            1: return (a - b + M) % M;
            2: return (M - 1) - (a & b);
            3: return (M - 1) - (a | b);
            4: return a ^ b;
            5: return (M - 1) - (a ^ b);
            6: return a * b;
            default: return 0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a sweep and serve n visits to CHECK_PC; visit i carries operands (i%M, i/M)
    task automatic run_sweep(input int op, input int bad_idx, input int bad_bit, input int nvis,
                             input bit pc8_on_start, input int long_idx, input int busy_start_idx);
        int a, b, v, gap, dwell;
        opsel = 3'(op);
        pc    = pc8_on_start ? 8'd8 : 8'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        pc    = 8'(($urandom_range(0, 7)));
        for (int i = 0; i < nvis; i++) begin
            a = i % M;
            b = i / M;
            v = gold(op, a, b);
            if (i == bad_idx) v = v ^ (1 << bad_bit);
            res_lo = DW'(v % M);
            res_hi = (op == 6) ? DW'(v / M) : DW'($urandom_range(0, M - 1));
            gap = $urandom_range(1, 3);
            for (int g = 0; g < gap; g++) begin
                pc = 8'($urandom_range(0, 7));
                if (i == busy_start_idx && g == 0) start = 1'b1;
                tick();
                start = 1'b0;
            end
            chk("opA_armed", op_a, a);
            chk("opB_armed", op_b, b);
            chk("busy_armed", busy, 1);
            dwell = (i == long_idx) ? 5 : $urandom_range(1, 3);
            pc = 8'd8;
            repeat (dwell) tick();
            chk("opA_held_at_pc", op_a, a);
            pc = 8'($urandom_range(0, 7));
            tick();
        end
    endtask

    initial begin
        int op3, bad3, bit3, base;

        // Reset state
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_timeout", tmo, 0);
        chk("rst_mismatch", mis, 0);
        chk("rst_okcnt", ok_cnt, 0);
        chk("rst_errcnt", err_cnt, 0);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk("idle_hold_busy", busy, 0);

        // ADD sweep, correct DUV; PC=8 on the start cycle and a start pulse while busy
        base = mis_pulses;
        run_sweep(0, -1, 0, NV, 1'b1, 3, 5);
        tick();
        chk("add_done", done, 1);
        chk("add_busy", busy, 0);
        chk("add_timeout", tmo, 0);
        chk("add_okcnt", ok_cnt, NV);
        chk("add_errcnt", err_cnt, 0);
        chk("add_mis_pulses", mis_pulses - base, 0);

        // MULT sweep restarted from DONE, bit0 corrupted at A=3,B=3
        base = mis_pulses;
        run_sweep(6, NV - 1, 0, NV, 1'b0, -1, -1);
        tick();
        chk("mult_done", done, 1);
        chk("mult_okcnt", ok_cnt, NV - 1);
        chk("mult_errcnt", err_cnt, 1);
        chk("mult_mis_pulses", mis_pulses - base, 1);
`ifdef CHECKER_FIRST_ERR_CAPTURE_EN
        chk("mult_fe_a", fe_a, 3);
        chk("mult_fe_b", fe_b, 3);
        chk("mult_fe_val", fe_val, 8);
`endif

        // Random bitwise/arith op with one random corrupted visit
        op3  = $urandom_range(1, 5);
        bad3 = $urandom_range(0, NV - 1);
        bit3 = $urandom_range(0, DW - 1);
        base = mis_pulses;
        run_sweep(op3, bad3, bit3, NV, 1'b0, -1, -1);
        tick();
        chk("rnd_done", done, 1);
        chk("rnd_okcnt", ok_cnt, NV - 1);
        chk("rnd_errcnt", err_cnt, 1);
        chk("rnd_mis_pulses", mis_pulses - base, 1);
`ifdef CHECKER_FIRST_ERR_CAPTURE_EN
        chk("rnd_fe_a", fe_a, bad3 % M);
        chk("rnd_fe_b", fe_b, bad3 / M);
        chk("rnd_fe_val", fe_val, gold(op3, bad3 % M, bad3 / M) ^ (1 << bit3));
`endif

        // Partial sweep to A=2,B=1, then asynchronous reset mid-cycle
        run_sweep(0, -1, 0, 6, 1'b0, -1, -1);
        tick();
        chk("mid_opA", op_a, 2);
        chk("mid_opB", op_b, 1);
        chk("mid_okcnt", ok_cnt, 6);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_busy", busy, 0);
        chk("async_rst_okcnt", ok_cnt, 0);
        chk("async_rst_opA", op_a, 0);
        chk("async_rst_opB", op_b, 0);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk("post_rst_idle", busy, 0);

        // Restart with PC never reaching 8: timeout after TMO cycles in ARM
        pc    = 8'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_opA", op_a, 0);
        chk("restart_opB", op_b, 0);
        chk("restart_busy", busy, 1);
        repeat (TMO - 1) tick();
        chk("pre_tmo_done", done, 0);
        chk("pre_tmo_busy", busy, 1);
        tick();
        chk("tmo_done", done, 1);
        chk("tmo_flag", tmo, 1);
        chk("tmo_busy", busy, 0);
        chk("tmo_okcnt", ok_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
